core_fetch: RTL and testbench
=============================

# core_fetch

Instruction-fetch stage of the in-order core pipeline, directly upstream of decode. It holds the PC, issues in-order requests to instruction memory, and buffers responses with their PCs in a small in-order queue. It presents one instruction per cycle to decode, holds it under the hazard-unit stall, and flushes on a redirect from execute, discarding responses still in flight.

## Interface
- `DEPTH`, 2: queue entries; also the cap on outstanding requests, including dropped ones. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `redirect_valid` in 1: taken branch/jump from execute; flush and restart.
- `redirect_pc` in 32: new fetch PC.
- `stall` in 1: decode hold from the hazard unit. Already qualified by decode valid and flush.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: request address (current PC).
- `imem_rsp_valid` in 1: in-order response. Always accepted, no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `d_valid` out 1: decode-side instruction valid.
- `d_pc` out 32: PC of the presented instruction.
- `d_instr` out 32: presented instruction word.

## Operation
- State:
  - `pc`.
  - Queue entries `{pc, instr, filled}`, with head/tail pointers of log2(DEPTH) bits plus a wrap bit.
  - `drop_cnt`, clog2(DEPTH+1) bits.
- `used` = allocated entries. `unfilled` = allocated entries not yet filled.
- `pop` = `d_valid & ~stall & ~redirect_valid`.
- Issue rule: `imem_req_valid = ~redirect_valid & (used + drop_cnt - pop < DEPTH)`. `imem_req_addr = pc`.
- Request acceptance (`req_valid & req_ready`):
  - Allocate the tail entry with `pc` and `filled=0`.
  - `pc <= pc + 4`, wrapping modulo 2^32.
- A request may be withdrawn before acceptance; the memory side tolerates this.
- Response handling:
  - If `drop_cnt > 0`: discard the response and decrement `drop_cnt`.
  - Otherwise: write `instr` into the oldest unfilled entry and set `filled`.
- Output: `d_valid` = head entry filled; `d_pc` and `d_instr` = head entry contents.
- Pop: advance head. While `stall`, outputs hold bit-stable.
- Redirect, which has priority over everything:
  - `pc <= redirect_pc`.
  - All entries invalidated (head = tail).
  - `drop_cnt <= drop_cnt + unfilled - imem_rsp_valid`.
  - No request is issued in that cycle.

## Timing
- Reset (`rst_n=0` at a clock edge), values in the next cycle:
  - `pc=RESET_PC`, queue empty, `drop_cnt=0`.
  - `d_valid=0`, `imem_req_valid=0` while `rst_n` is low.
  - `d_pc`/`d_instr` are don't-care.
- The first request is issued in the first cycle with `rst_n=1`.
- Reset mid-operation: all state is cleared, and responses to pre-reset requests are not expected.
- Latency: request accepted at T with response at T+k gives `d_valid` at T+k+1. With k=1, fetch-to-decode is 2 cycles.
- Throughput: with k=1 and DEPTH=2, one instruction per cycle sustained with no stalls.
- Full: when `used + drop_cnt = DEPTH` and there is no pop, `imem_req_valid=0`.
- Pop and allocate may happen in the same cycle when full.
- Empty: `d_valid=0`. A response arriving at cycle T is visible at T+1, never combinationally.
- Same-cycle events:
  - Redirect + response: the response is counted as consumed in the `drop_cnt` formula and its data is discarded.
  - Redirect + stall: flush wins.
  - Response fill + pop: both occur.
  - Response + `drop_cnt>0`: always dropped, even if entries are unfilled.
- Redirect cycle: `d_valid` still reflects pre-flush state. The next cycle, `d_valid=0`.
- The first post-redirect request is issued at redirect+1 with address `redirect_pc`.
- Back-to-back redirects: the last one wins, and `drop_cnt` accumulates.
- Invariant: `used + drop_cnt ≤ DEPTH`. A response while `used - filled + drop_cnt = 0` is illegal (assert).

## Structure
- `core_pkg` holds:
  - `XLEN=32` and the default `RESET_PC`.
  - `fetch_entry_t` struct `{pc, instr, filled}`.
  - The instruction-word type shared with decode.
- Sub-module `core_fetch_queue`: in-order queue with allocate at tail, fill-oldest-unfilled, pop at head, flush, and `used`/`unfilled` counts.
- `core_fetch` holds the PC, issue logic, drop counter and redirect control.

## Test plan
- Reset release, 1-cycle memory, no stalls:
  - Requests at 0x0, 0x4, 0x8, … on consecutive cycles.
  - `d_valid` first high 2 cycles after reset release, then high every cycle with incrementing `d_pc`.
- `stall` held 3 cycles while `d_pc=0x8`:
  - `d_pc`/`d_instr` stable across all 3 cycles.
  - At most DEPTH entries outstanding, and `imem_req_valid=0` once full.
  - Stream resumes at 0xC with no loss or duplication.
- Redirect to 0x100 with 2 requests in flight and 3-cycle memory latency:
  - Both old responses are discarded.
  - The next `d_pc` after the flush is 0x100.
- Redirect in the same cycle as a response, with 1 other outstanding:
  - `drop_cnt=1` afterwards.
  - The following response is dropped and the one after that appears at `redirect_pc`.
- `imem_req_ready` low for 5 cycles:
  - `imem_req_addr` holds and the PC does not advance.
  - No `d_valid` bubble beyond the buffered entries.
- `rst_n` asserted with a full queue and `drop_cnt>0`:
  - Next cycle `d_valid=0`, `drop_cnt=0`, `pc=RESET_PC`.
  - Restart is clean.

Source files
------------

// File: rtl/core_pkg.sv
// Types and constants shared by the fetch stage and its neighbours in the core.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [31:0] instr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    instr_t          instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/core_fetch_queue.sv
// In-order fetch buffer: allocate at tail, fill the oldest unfilled entry,
// pop at head, and flush everything in one cycle.
module core_fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       alloc,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic                       fill,
  input  logic [31:0]                fill_instr,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [XLEN-1:0]            head_pc,
  output logic [31:0]                head_instr,
  output logic [$clog2(DEPTH):0]     used,
  output logic [$clog2(DEPTH):0]     unfilled
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] fill_q, fill_d;
  fetch_entry_t  entry_q [DEPTH];
  fetch_entry_t  entry_d [DEPTH];

  logic [PW-1:0] head_idx, tail_idx, fill_idx;

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign fill_idx = fill_q[PW-1:0];

  // The fill pointer always sits between head and tail, so responses land in
  // request order without searching the entries.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    if (flush) begin
      head_d = tail_q;
      fill_d = tail_q;
    end else begin
      if (alloc) tail_d = tail_q + CW'(1);
      if (fill)  fill_d = fill_q + CW'(1);
      if (pop)   head_d = head_q + CW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    if (!flush) begin
      if (alloc) begin
        entry_d[tail_idx].pc     = alloc_pc;
        entry_d[tail_idx].filled = 1'b0;
      end
      if (fill) begin
        entry_d[fill_idx].instr  = fill_instr;
        entry_d[fill_idx].filled = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
    end
  end

  // Entry payload needs no reset: an empty queue masks stale filled bits.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  always_comb begin
    used       = tail_q - head_q;
    unfilled   = tail_q - fill_q;
    head_valid = (used != '0) && entry_q[head_idx].filled;
    head_pc    = entry_q[head_idx].pc;
    head_instr = entry_q[head_idx].instr;
  end

endmodule

// File: rtl/core_fetch.sv
// Instruction-fetch stage: PC, request issue, response buffering and
// redirect flush with a counter of in-flight responses to discard.
module core_fetch
  import core_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] used, unfilled;
  logic          head_valid;
  logic [31:0]   head_pc, head_instr;
  logic          pop, accept, fill, rsp_drop;
  logic [CW:0]   occupancy;

  core_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .alloc      (accept),
    .alloc_pc   (pc_q),
    .fill       (fill),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .used       (used),
    .unfilled   (unfilled)
  );

  // Dropped responses still occupy memory-side slots, so they count against
  // the outstanding cap; a same-cycle pop frees a slot early.
  always_comb begin
    d_valid        = rst_n & head_valid;
    d_pc           = head_pc;
    d_instr        = head_instr;
    pop            = d_valid & ~stall & ~redirect_valid;
    occupancy      = {1'b0, used} + {1'b0, drop_cnt_q} - (CW+1)'(pop);
    imem_req_valid = rst_n & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
    imem_req_addr  = pc_q;
    accept         = imem_req_valid & imem_req_ready;
    rsp_drop       = imem_rsp_valid & (drop_cnt_q != '0);
    fill           = imem_rsp_valid & ~rsp_drop & ~redirect_valid;

    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      drop_cnt_d = drop_cnt_q + unfilled - CW'(imem_rsp_valid);
    end else begin
      if (accept)   pc_d       = pc_q + 32'd4;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ({1'b0, used} + {1'b0, drop_cnt_q} <= (CW+1)'(DEPTH));
      if (imem_rsp_valid) assert ((unfilled != '0) || (drop_cnt_q != '0));
    end
  end
`endif

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: per-cycle vector table plus hand-written
// redirect and reset sequences against an in-order latency memory model.
module tb_core_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;

  core_fetch #(
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .d_valid        (d_valid),
    .d_pc           (d_pc),
    .d_instr        (d_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        rn;
    logic        st;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
  } vec_t;

  pend_t pend[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc_n    = 0;
  int    lat      = 1;
  vec_t  vecs[21];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t v(input logic rn, input logic st, input logic rdy,
                             input logic er, input logic [31:0] ea,
                             input logic ed, input logic [31:0] ep);
    vec_t r;
    r.rn = rn; r.st = st; r.rdy = rdy;
    r.e_req = er; r.e_addr = ea; r.e_dv = ed; r.e_pc = ep;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs and memory response, settle, compare, then
  // record an accepted request and advance to the next falling edge.
  task automatic cyc(input logic rn, input logic st, input logic rdy,
                     input logic rv, input logic [31:0] rpc,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_dv, input logic [31:0] e_pc, input string tag);
    pend_t p;
    rst_n = rn; stall = st; imem_req_ready = rdy;
    redirect_valid = rv; redirect_pc = rpc;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    if (!rn) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, e_req});
    if (e_req) chk({tag, ".req_addr"}, imem_req_addr, e_addr);
    chk({tag, ".d_valid"}, {31'b0, d_valid}, {31'b0, e_dv});
    if (e_dv) begin
      chk({tag, ".d_pc"}, d_pc, e_pc);
      chk({tag, ".d_instr"}, d_instr, word_of(e_pc));
    end
    $display("cyc %0d %s rst_n=%b stall=%b rdy=%b redir=%b rsp=%b req=%b@%h d=%b@%h",
             cyc_n, tag, rn, st, rdy, rv, imem_rsp_valid, imem_req_valid,
             imem_req_addr, d_valid, d_pc);
    if (rn && imem_req_valid && imem_req_ready) begin
      p.addr = imem_req_addr;
      p.due  = cyc_n + lat;
      pend.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset release, 1-cycle memory, 3-cycle stall at 0x8, then ready low 5 cycles.
    vecs[0]  = v(0, 0, 1, 0, 32'h00, 0, 32'h00);
    vecs[1]  = v(0, 0, 1, 0, 32'h00, 0, 32'h00);
    vecs[2]  = v(1, 0, 1, 1, 32'h00, 0, 32'h00);
    vecs[3]  = v(1, 0, 1, 1, 32'h04, 0, 32'h00);
    vecs[4]  = v(1, 0, 1, 1, 32'h08, 1, 32'h00);
    vecs[5]  = v(1, 0, 1, 1, 32'h0C, 1, 32'h04);
    vecs[6]  = v(1, 1, 1, 0, 32'h00, 1, 32'h08);
    vecs[7]  = v(1, 1, 1, 0, 32'h00, 1, 32'h08);
    vecs[8]  = v(1, 1, 1, 0, 32'h00, 1, 32'h08);
    vecs[9]  = v(1, 0, 1, 1, 32'h10, 1, 32'h08);
    vecs[10] = v(1, 0, 1, 1, 32'h14, 1, 32'h0C);
    vecs[11] = v(1, 0, 1, 1, 32'h18, 1, 32'h10);
    vecs[12] = v(1, 0, 1, 1, 32'h1C, 1, 32'h14);
    vecs[13] = v(1, 0, 0, 1, 32'h20, 1, 32'h18);
    vecs[14] = v(1, 0, 0, 1, 32'h20, 1, 32'h1C);
    vecs[15] = v(1, 0, 0, 1, 32'h20, 0, 32'h00);
    vecs[16] = v(1, 0, 0, 1, 32'h20, 0, 32'h00);
    vecs[17] = v(1, 0, 0, 1, 32'h20, 0, 32'h00);
    vecs[18] = v(1, 0, 1, 1, 32'h20, 0, 32'h00);
    vecs[19] = v(1, 0, 1, 1, 32'h24, 0, 32'h00);
    vecs[20] = v(1, 0, 1, 1, 32'h28, 1, 32'h20);

    @(negedge clk);
    lat = 1;
    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].rn, vecs[i].st, vecs[i].rdy, 1'b0, 32'h0,
          vecs[i].e_req, vecs[i].e_addr, vecs[i].e_dv, vecs[i].e_pc,
          $sformatf("row%0d", i));
    end

    // Redirect to 0x100 with two requests in flight, 3-cycle memory.
    lat = 3;
    cyc(0, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "C0");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   "C1");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0,   "C2");
    cyc(1, 0, 1, 1, 32'h100, 0, 32'h0,   0, 32'h0,   "C3");
    chk("C.drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    cyc(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "C4");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   "C5");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0,   "C6");
    cyc(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "C7");
    cyc(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "C8");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100, "C9");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104, "C10");

    // Redirect coinciding with a response, one other outstanding; then a
    // redirect while d_valid is high.
    lat = 2;
    cyc(0, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "D0");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   "D1");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0,   "D2");
    cyc(1, 0, 1, 1, 32'h200, 0, 32'h0,   0, 32'h0,   "D3");
    chk("D.drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0,   "D4");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0,   "D5");
    cyc(1, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "D6");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h208, 1, 32'h200, "D7");
    cyc(1, 1, 1, 1, 32'h400, 0, 32'h0,   1, 32'h204, "D8");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h400, 0, 32'h0,   "D9");

    // Reset with the cap reached and drop_cnt>0, then a clean restart.
    lat = 4;
    cyc(0, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "E0");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   "E1");
    cyc(1, 0, 1, 1, 32'h300, 0, 32'h0,   0, 32'h0,   "E2");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h300, 0, 32'h0,   "E3");
    chk("E.drop_cnt_pre", 32'(dut.drop_cnt_q), 32'd1);
    lat = 1;
    cyc(0, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   "E4");
    chk("E.drop_cnt_post", 32'(dut.drop_cnt_q), 32'd0);
    chk("E.pc_post", dut.pc_q, 32'h0);
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   "E5");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0,   "E6");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0,   "E7");
    cyc(1, 0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4,   "E8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
